tube_hit_packer: RTL

// Upstream stage of the drift-tube readout FIFO. It opens a fixed capture window on each

---
 rtl/tube_hit_packer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tube_hit_packer.sv
// rtl/tube_hit_packer.sv - drift-tube hit capture window and 16-bit event packer for the readout FIFO
// Optional feature macro: TUBE_SYNC_EN (two-flop synchronizer ahead of edge detect on all 33 inputs)
module tube_hit_packer #(
    parameter int WINDOW_CYCLES = 40
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic        SCIN_COIN,
    input  logic [7:0]  TUBE3A,
    input  logic [7:0]  TUBE3B,
    input  logic [7:0]  TUBE4A,
    input  logic [7:0]  TUBE4B,
    input  logic        WR_FULL,
    output logic [15:0] WR_DATA,
    output logic        WR_EN,
    output logic        overflowLight,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WINDOW, DRAIN, TRAILER} state_t;

    localparam logic [7:0] T_LAST = 8'(WINDOW_CYCLES - 1);

    state_t      state, state_n;
    logic [32:0] raw_in, cur_in, prev_in, rise;
    logic [31:0] mask;
    logic [7:0]  hit_time [32];
    logic [7:0]  t_cnt;
    logic [4:0]  idx;
    logic [5:0]  nhits;
    logic [11:0] evt;
    logic        coin_rise;
    logic        capture, accept, drop, emit_hit, emit_trailer, advance;
    logic [7:0]  cap_time;

    // Bit 32 is the coincidence, bits 31:0 are tube channels 0..31
    assign raw_in = {SCIN_COIN, TUBE4B, TUBE4A, TUBE3B, TUBE3A};

`ifdef TUBE_SYNC_EN
    logic [32:0] sync_q1, sync_q2;

    // Two-flop synchronizer; equal delay on coincidence and tubes keeps recorded times unchanged
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end
    assign cur_in = sync_q2;
`else
    assign cur_in = raw_in;
`endif

    // Edge history for rising-edge detection, updated every cycle
    always_ff @(posedge clk100) begin
        if (!rst_n) prev_in <= '0;
        else        prev_in <= cur_in;
    end

    assign rise      = cur_in & ~prev_in;
    assign coin_rise = rise[32];
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk100) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        state_n      = state;
        capture      = 1'b0;
        cap_time     = t_cnt;
        accept       = 1'b0;
        drop         = 1'b0;
        emit_hit     = 1'b0;
        emit_trailer = 1'b0;
        advance      = 1'b0;
        case (state)
            IDLE: begin
                if (coin_rise) begin
                    if (WR_FULL) begin
                        drop = 1'b1;
                    end else begin
                        // The detect cycle is t=0 of the window
                        accept   = 1'b1;
                        capture  = 1'b1;
                        cap_time = '0;
                        state_n  = (WINDOW_CYCLES == 1) ? DRAIN : WINDOW;
                    end
                end
            end
            WINDOW: begin
                capture = 1'b1;
                if (t_cnt == T_LAST) state_n = DRAIN;
            end
            DRAIN: begin
                if (mask[idx]) begin
                    if (!WR_FULL) begin
                        emit_hit = 1'b1;
                        advance  = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
                if (advance && idx == 5'd31) state_n = TRAILER;
            end
            TRAILER: begin
                if (!WR_FULL) begin
                    emit_trailer = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Window time, drain index, hit count and event number
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            t_cnt <= '0;
            idx   <= '0;
            nhits <= '0;
            evt   <= '0;
        end else begin
            if (accept)               t_cnt <= 8'd1;
            else if (state == WINDOW) t_cnt <= t_cnt + 8'd1;
            if (state != DRAIN)       idx <= '0;
            else if (advance)         idx <= idx + 5'd1;
            if (accept)               nhits <= '0;
            else if (emit_hit)        nhits <= nhits + 6'd1;
            if (state == IDLE && coin_rise) evt <= evt + 12'd1;
        end
    end

    // First-rise capture per channel; mask cleared once the trailer is written
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            mask <= '0;
            for (int i = 0; i < 32; i++) hit_time[i] <= '0;
        end else if (emit_trailer) begin
            mask <= '0;
        end else if (capture) begin
            for (int i = 0; i < 32; i++) begin
                if (rise[i] && !mask[i]) begin
                    mask[i]     <= 1'b1;
                    hit_time[i] <= cap_time;
                end
            end
        end
    end

    // Registered FIFO write port and sticky overflow flag; data holds when no write
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            WR_EN         <= 1'b0;
            WR_DATA       <= '0;
            overflowLight <= 1'b0;
        end else begin
            WR_EN <= accept | emit_hit | emit_trailer;
            if (accept)            WR_DATA <= {4'hF, evt};
            else if (emit_hit)     WR_DATA <= {1'b0, idx, 2'b00, hit_time[idx]};
            else if (emit_trailer) WR_DATA <= {4'hE, 6'b0, nhits};
            if (drop)              overflowLight <= 1'b1;
        end
    end
endmodule
